// File: rtl/f100l_pkg.sv
// Shared definitions for the F100-L program loader: frame constants and the
// loader state encoding.
package f100l_pkg;

  localparam int         PROGRAM_DEPTH    = 1024;
  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_COUNT_HI,
    LD_COUNT_LO,
    LD_DATA_HI,
    LD_DATA_LO,
    LD_WRITE,
    LD_CHECKSUM,
    LD_DONE,
    LD_ERROR
  } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Assembles a framed host byte stream into 16-bit program words, writes them
// to program RAM and holds the F100-L core in reset until a frame checks out.
module program_loader
  import f100l_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 10,
  parameter int         DEPTH        = PROGRAM_DEPTH,
  parameter int         BASE_ADDRESS = 0,
  parameter logic [7:0] SYNC_BYTE    = LOADER_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [15:0]           mem_data_out,
  output logic                  mem_write_enable,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  loader_state_e         state, state_next;
  logic [15:0]           count_q, count_next, count_full;
  logic [15:0]           counter_q, counter_next;
  logic [7:0]            sum_q, sum_next;
  logic [7:0]            hi_q, hi_next;
  logic [15:0]           data_q, data_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic                  we_q, we_next;
  logic                  ready_q, ready_next;
  logic                  hold_q, hold_next;
  logic                  busy_q, busy_next;
  logic                  done_q, done_next;
  logic                  error_q, error_next;
  logic                  accept;

  always_comb begin
    state_next   = state;
    count_next   = count_q;
    counter_next = counter_q;
    sum_next     = sum_q;
    hi_next      = hi_q;
    data_next    = data_q;
    addr_next    = addr_q;
    we_next      = 1'b0;
    hold_next    = hold_q;
    busy_next    = busy_q;
    done_next    = done_q;
    error_next   = error_q;
    accept       = rx_valid && ready_q;
    count_full   = {count_q[15:8], rx_data};

    unique case (state)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_next = LD_COUNT_HI;
          done_next  = 1'b0;
          error_next = 1'b0;
          busy_next  = 1'b1;
          hold_next  = 1'b1;
        end
      end
      LD_COUNT_HI: begin
        if (accept) begin
          count_next[15:8] = rx_data;
          state_next       = LD_COUNT_LO;
        end
      end
      LD_COUNT_LO: begin
        if (accept) begin
          count_next = count_full;
          if (count_full == 16'd0 || 32'(count_full) > 32'(DEPTH)) begin
            state_next = LD_ERROR;
            error_next = 1'b1;
            busy_next  = 1'b0;
          end else begin
            state_next   = LD_DATA_HI;
            counter_next = 16'd0;
            sum_next     = 8'd0;
          end
        end
      end
      LD_DATA_HI: begin
        if (accept) begin
          hi_next    = rx_data;
          sum_next   = sum_q + rx_data;
          state_next = LD_DATA_LO;
        end
      end
      LD_DATA_LO: begin
        if (accept) begin
          data_next  = {hi_q, rx_data};
          sum_next   = sum_q + rx_data;
          addr_next  = ADDR_WIDTH'(32'(BASE_ADDRESS) + 32'(counter_q));
          we_next    = 1'b1;
          state_next = LD_WRITE;
        end
      end
      LD_WRITE: begin
        counter_next = counter_q + 16'd1;
        state_next   = (counter_q + 16'd1 == count_q) ? LD_CHECKSUM : LD_DATA_HI;
      end
      LD_CHECKSUM: begin
        if (accept) begin
          busy_next = 1'b0;
          if (rx_data == sum_q) begin
            state_next = LD_DONE;
            done_next  = 1'b1;
            hold_next  = 1'b0;
          end else begin
            state_next = LD_ERROR;
            error_next = 1'b1;
          end
        end
      end
      default: state_next = LD_IDLE;
    endcase

    ready_next = (state_next != LD_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LD_IDLE;
      count_q   <= 16'd0;
      counter_q <= 16'd0;
      sum_q     <= 8'd0;
      hi_q      <= 8'd0;
      data_q    <= 16'd0;
      addr_q    <= ADDR_WIDTH'(BASE_ADDRESS);
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_next;
      count_q   <= count_next;
      counter_q <= counter_next;
      sum_q     <= sum_next;
      hi_q      <= hi_next;
      data_q    <= data_next;
      addr_q    <= addr_next;
      we_q      <= we_next;
      ready_q   <= ready_next;
      hold_q    <= hold_next;
      busy_q    <= busy_next;
      done_q    <= done_next;
      error_q   <= error_next;
    end
  end

  // Gating the strobe with reset kills a write already pending when reset lands.
  assign mem_write_enable = we_q & reset;
  assign rx_ready         = ready_q;
  assign mem_address      = addr_q;
  assign mem_data_out     = data_q;
  assign cpu_hold         = hold_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: checks writes, status flags, handshake,
// mid-frame reset and address wrap against hand-computed values.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready, rx_ready_b;
  logic [9:0]  mem_address, mem_address_b;
  logic [15:0] mem_data_out, mem_data_out_b;
  logic        mem_write_enable, mem_write_enable_b;
  logic        cpu_hold, cpu_hold_b;
  logic        busy, busy_b;
  logic        done, done_b;
  logic        error, error_b;

  int testCount = 0;
  int failCount = 0;
  int gapMax    = 0;

  logic [9:0]  wrAddr[$];
  logic [15:0] wrData[$];
  logic [9:0]  wrAddrB[$];

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_write_enable(mem_write_enable), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error)
  );

  program_loader #(.BASE_ADDRESS(1022)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_b), .mem_address(mem_address_b), .mem_data_out(mem_data_out_b),
    .mem_write_enable(mem_write_enable_b), .cpu_hold(cpu_hold_b), .busy(busy_b),
    .done(done_b), .error(error_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one byte and hold it until the loader takes it on a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    repeat ($urandom_range(0, gapMax)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("handshake_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) applyStimulus(bytes[i]);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_we"},       32'(mem_write_enable), 32'd0);
    checkOutput({tag, "_addr"},     32'(mem_address), 32'd0);
    checkOutput({tag, "_data"},     32'(mem_data_out), 32'd0);
    checkOutput({tag, "_hold"},     32'(cpu_hold), 32'd0);
    checkOutput({tag, "_busy"},     32'(busy), 32'd0);
    checkOutput({tag, "_done"},     32'(done), 32'd0);
    checkOutput({tag, "_error"},    32'(error), 32'd0);
  endtask

  task automatic checkStatus(input string tag, input logic eDone, input logic eError, input logic eHold);
    checkOutput({tag, "_done"},  32'(done), 32'(eDone));
    checkOutput({tag, "_error"}, 32'(error), 32'(eError));
    checkOutput({tag, "_hold"},  32'(cpu_hold), 32'(eHold));
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  task automatic checkTwoWords(input string tag);
    checkOutput({tag, "_wcount"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      checkOutput({tag, "_addr0"}, 32'(wrAddr[0]), 32'd0);
      checkOutput({tag, "_data0"}, 32'(wrData[0]), 32'h8000);
      checkOutput({tag, "_addr1"}, 32'(wrAddr[1]), 32'd1);
      checkOutput({tag, "_data1"}, 32'(wrData[1]), 32'h0014);
    end
  endtask

  task automatic clearCapture();
    wrAddr.delete();
    wrData.delete();
    wrAddrB.delete();
  endtask

  // Write capture; the loader must not offer rx_ready while strobing.
  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      wrAddr.push_back(mem_address);
      wrData.push_back(mem_data_out);
      checkOutput("ready_in_write", 32'(rx_ready), 32'd0);
    end
    if (mem_write_enable_b === 1'b1) wrAddrB.push_back(mem_address_b);
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(rx_ready), 32'd1);

    // Test 1: good two-word frame
    clearCapture();
    applyStimulus(8'hA5);
    checkOutput("t1_busy_after_sync", 32'(busy), 32'd1);
    checkOutput("t1_hold_after_sync", 32'(cpu_hold), 32'd1);
    sendFrame('{8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h14, 8'h94});
    checkStatus("t1", 1'b1, 1'b0, 1'b0);
    checkTwoWords("t1");

    // Test 2: bad checksum
    clearCapture();
    sendFrame('{8'hA5, 8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h14, 8'h95});
    checkStatus("t2", 1'b0, 1'b1, 1'b1);
    checkTwoWords("t2");

    // Test 3: count boundaries
    clearCapture();
    applyStimulus(8'hA5);
    checkOutput("t3_error_cleared", 32'(error), 32'd0);
    sendFrame('{8'h00, 8'h00});
    checkStatus("t3_zero", 1'b0, 1'b1, 1'b1);
    sendFrame('{8'hA5, 8'h04, 8'h01});
    checkStatus("t3_1025", 1'b0, 1'b1, 1'b1);
    sendFrame('{8'hA5, 8'h04, 8'h00});
    checkOutput("t3_1024_busy", 32'(busy), 32'd1);
    checkOutput("t3_1024_error", 32'(error), 32'd0);
    checkOutput("t3_no_writes", 32'(wrAddr.size()), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("t3_abort");
    reset = 1'b1;

    // Test 4: leading junk and gappy rx_valid
    clearCapture();
    gapMax = 3;
    sendFrame('{8'h12, 8'h34});
    checkOutput("t4_junk_busy", 32'(busy), 32'd0);
    checkOutput("t4_junk_hold", 32'(cpu_hold), 32'd0);
    sendFrame('{8'hA5, 8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h14, 8'h94});
    checkStatus("t4", 1'b1, 1'b0, 1'b0);
    checkTwoWords("t4");
    gapMax = 0;

    // Test 5: reset lands in the first WRITE cycle
    clearCapture();
    sendFrame('{8'hA5, 8'h00, 8'h02, 8'h80, 8'h00});
    reset = 1'b0;
    #1;
    checkOutput("t5_we_suppressed", 32'(mem_write_enable), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkResetValues("t5_reset");
    checkOutput("t5_no_writes", 32'(wrAddr.size()), 32'd0);
    reset = 1'b1;
    sendFrame('{8'hA5, 8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h14, 8'h94});
    checkStatus("t5", 1'b1, 1'b0, 1'b0);
    checkTwoWords("t5");

    // Test 6: address wrap on the BASE_ADDRESS=1022 instance
    clearCapture();
    sendFrame('{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h64});
    checkOutput("t6_done_b", 32'(done_b), 32'd1);
    checkOutput("t6_hold_b", 32'(cpu_hold_b), 32'd0);
    checkOutput("t6_wcount_b", 32'(wrAddrB.size()), 32'd4);
    if (wrAddrB.size() == 4) begin
      checkOutput("t6_addr0", 32'(wrAddrB[0]), 32'd1022);
      checkOutput("t6_addr1", 32'(wrAddrB[1]), 32'd1023);
      checkOutput("t6_addr2", 32'(wrAddrB[2]), 32'd0);
      checkOutput("t6_addr3", 32'(wrAddrB[3]), 32'd1);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
